// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, column helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam logic [3:0] COL_RST = 4'b1110;

  // Indexed by {row,col}; entry 0 is (r0,c0), entry 15 is (r3,c3).
  localparam logic [15:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

  // Lowest-index active-low row; only meaningful when at least one row is low.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] rot_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer with a configurable reset value; used for the keypad row inputs.
module sync2 #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with press/release debounce and a two-digit key history.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REPEAT_CYCLES   = 1 << 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] new_digit,
  output logic [3:0] old_digit
);

  localparam int MAX_SD = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAXC   = (MAX_SD > REPEAT_CYCLES) ? MAX_SD : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  logic [3:0]    rs;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    col;
  logic [1:0]    row;
  logic [3:0]    code;

  sync2 #(.W(4), .RST_VAL(4'hF)) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rs)
  );

  assign code = key_code(row, col);

  // The counter is shared: scan slot timer, debounce timer and repeat timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      cnt       <= '0;
      cols      <= COL_RST;
      col       <= 2'd0;
      row       <= 2'd0;
      key       <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      new_digit <= 4'd0;
      old_digit <= 4'd0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (rs != 4'hF) begin
              row   <= low_row(rs);
              state <= PRESS_DB;
            end else begin
              cols <= rot_col(cols);
              col  <= col + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESS_DB: begin
          if (rs[row]) begin
            state <= SCAN;
            cnt   <= '0;
            cols  <= rot_col(cols);
            col   <= col + 2'd1;
          end else if (cnt == DB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            key       <= code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            old_digit <= new_digit;
            new_digit <= code;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (rs[row]) begin
            state <= RELEASE_DB;
            cnt   <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (cnt == RPT_LAST) begin
            cnt       <= '0;
            key_valid <= 1'b1;
            old_digit <= new_digit;
            new_digit <= key;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RELEASE_DB: begin
          if (!rs[row]) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state    <= SCAN;
            cnt      <= '0;
            key_held <= 1'b0;
            cols     <= rot_col(cols);
            col      <= col + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 hex keypad matrix and debounces it. Each confirmed key press becomes a one-cycle event carrying a 4-bit hex code. The block also keeps a two-digit history (newest and previous key) that drives the dual seven-segment display path directly. It is the input-side counterpart of the time-multiplexed display: it drives the matrix columns and reads the rows back, where the display drives segments and selects.

## Interface
- SCAN_DIV, default 4096: clock cycles each column stays driven while scanning. Must be at least 4.
- DEBOUNCE_CYCLES, default 65536: continuous stable cycles needed to accept a press or a release.
- REPEAT_CYCLES, default 2^22: auto-repeat period; used only when KEYPAD_REPEAT_EN is defined.
- clk  input  1  system clock. The only clock.
- reset  input  1  asynchronous, active-high reset.
- rows  input  4  matrix rows, active-low (external pull-ups), asynchronous to clk.
- cols  output  4  column drive, one-hot active-low.
- key  output  4  hex code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a key is accepted.
- key_held  output  1  high while the accepted key is held down.
- new_digit  output  4  most recent key.
- old_digit  output  4  key accepted before new_digit.

## Operation
- rows passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Key map by (row,col), with 0 as the first index:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - cols rotates 1110 → 1101 → 1011 → 0111 → 1110, holding each value for SCAN_DIV cycles.
  - On the last cycle of a column slot, if rs ≠ 4'hF: capture the column and the lowest-index low row, freeze cols, go to PRESS_DB.
  - Otherwise, rotate to the next column.
- PRESS_DB:
  - Counter counts cycles while the captured row stays low.
  - Captured row goes high → go to SCAN and advance to the next column. No output.
  - Count reaches DEBOUNCE_CYCLES → go to HELD. In the same cycle: latch key, pulse key_valid, set old_digit ← new_digit and new_digit ← key code.
- HELD:
  - key_held = 1. cols stays frozen. Any other key is ignored (no multi-key rollover).
  - Captured row goes high → go to RELEASE_DB with the counter cleared.
- RELEASE_DB:
  - Counter counts continuous high cycles of the captured row.
  - Row goes low again → clear the counter and return to HELD. No new key_valid.
  - Count reaches DEBOUNCE_CYCLES → go to SCAN with the next column and key_held = 0.
- Counter width: $clog2 of the largest of SCAN_DIV, DEBOUNCE_CYCLES and REPEAT_CYCLES, plus 1. The counter never wraps; it clears on every state change.

## Timing
- Reset values:
  - cols = 4'b1110
  - key = 0, key_valid = 0, key_held = 0
  - new_digit = 0, old_digit = 0
  - state = SCAN, counter = 0, synchronizer flops = 4'hF
- Reset mid-press: outputs return to their reset values immediately. After reset is released, a key still held is re-scanned and produces a fresh key_valid after debounce.
- Input-to-event latency: 2 cycles (sync) + wait for the column's sample slot + DEBOUNCE_CYCLES, then key_valid on the next edge.
- SCAN_DIV ≥ 4 guarantees rs reflects the current column before the sample point.
- key_valid is never high on two consecutive cycles.
- new_digit, old_digit and key update on the same edge that raises key_valid.
- Simultaneous presses: the lowest row within the first-scanned column wins. Releasing the winning key while another key is still held: after RELEASE_DB, the other key is found by a normal scan.

## Configuration
- KEYPAD_REPEAT_EN defined: in HELD, the counter runs. Each time it reaches REPEAT_CYCLES, the block pulses key_valid, shifts the digits again, and clears the counter.
- KEYPAD_REPEAT_EN undefined: the repeat logic is absent. Exactly one key_valid per press.

## Structure
- keypad_pkg holds:
  - the state enum (SCAN, PRESS_DB, HELD, RELEASE_DB)
  - the 16-entry key-map constant indexed by {row,col}
  - the reset column constant 4'b1110
- Sub-module sync2: a 2-flop synchronizer, 4 bits wide, with reset value 1, instantiated once for rows.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- Idle with rows = 4'hF → cols cycles 1110, 1101, 1011, 0111 every 4 cycles; key_valid never asserts.
- Press (r1,c2) stable → exactly one key_valid; key = 6; new_digit = 6; old_digit = 0; key_held = 1 until release plus 8 cycles.
- Press 5 then press 9 → new_digit = 9 and old_digit = 5 after the second key_valid.
- Bounce: row low for 3 cycles, high for 2, repeated → no key_valid. A clean 8-cycle low → one key_valid.
- Release glitch: while held, row high for 5 cycles then low → no second key_valid; key_held stays 1.
- Assert reset during PRESS_DB → all outputs reset at once. Key still held after reset → one key_valid after debounce. With KEYPAD_REPEAT_EN and REPEAT_CYCLES=16, holding D gives a key_valid every 16 cycles.
